uart_tx_buffer: RTL and testbench
=================================

UART_TX_BUFFER -- requirements
Module: uart_tx_buffer

Interface
REQ-001 Parameter: DEPTH, 16, FIFO entries; SHALL be a power of two, 2..256.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 Port: clk  input  1  system clock; all logic SHALL be rising-edge clk.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: wr_data  input  8  host byte to enqueue.
REQ-006 Port: wr_en  input  1  enqueue request, one byte per asserted cycle.
REQ-007 Port: flush  input  1  synchronous FIFO discard.
REQ-008 Port: full  output  1  FIFO holds DEPTH entries.
REQ-009 Port: empty  output  1  FIFO holds zero entries.
REQ-010 Port: count  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-011 Port: tx_data  output  8  byte presented to the transmitter data input.
REQ-012 Port: tx_send  output  1  transmit request to the transmitter send input.
REQ-013 Port: tx_ready  input  1  transmitter idle indication.
REQ-014 Port: overflow  output  1  sticky write-while-full flag.
REQ-015 Port: ovf_clr  input  1  clears overflow.

Function
REQ-016 Storage SHALL be a circular buffer with wrapping read/write pointers; count SHALL be 0..DEPTH.
REQ-017 A write SHALL occur when wr_en=1 and full=0; wr_en with full=1 SHALL be dropped, leaving contents and pointers unchanged.
REQ-018 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-019 Control FSM states SHALL be IDLE, REQ, BUSY.
REQ-020 IDLE: if empty=0 and tx_ready=1, the head entry SHALL be popped into the tx_data register and the FSM SHALL enter REQ on the next edge.
REQ-021 REQ: tx_send SHALL be 1; tx_data SHALL be held; on tx_ready=0 the FSM SHALL enter BUSY.
REQ-022 BUSY: tx_send SHALL be 0; tx_data SHALL be held; on tx_ready=1 the FSM SHALL enter IDLE.
REQ-023 tx_send SHALL be registered and asserted only in REQ; tx_data SHALL change only on a pop.
REQ-024 Minimum IDLE dwell SHALL be one cycle between consecutive bytes. The transmitter's internal enable clears one cycle after tx_ready rises.
REQ-025 Simultaneous write and pop SHALL both take effect; count SHALL be unchanged.
REQ-026 The full check for a write SHALL use pre-edge state. A write when full=1 SHALL be dropped even if a pop occurs in the same cycle.
REQ-027 A write when empty=1 SHALL NOT bypass to tx_data in the same cycle; the earliest pop SHALL be the following cycle.
REQ-028 flush=1 SHALL zero both pointers and count at the next edge and ignore a same-cycle wr_en.
REQ-029 flush SHALL NOT alter FSM state, tx_data or tx_send, so an in-flight byte completes.
REQ-030 Byte order out SHALL equal byte order in; bytes SHALL NOT be lost or duplicated.

Reset
REQ-031 rst=1 SHALL have priority over every other input.
REQ-032 rst=1 SHALL force the FSM to IDLE, pointers to 0, count=0, empty=1, full=0, tx_send=0, tx_data=8'h00 and overflow=0 at the next edge.
REQ-033 Reset mid-transfer SHALL abandon the byte in flight without re-sending it.
REQ-034 FIFO storage contents SHALL need no reset.

Configuration
REQ-035 Macro UART_TX_BUFFER_OVERFLOW_EN SHALL control the overflow logic.
REQ-036 With UART_TX_BUFFER_OVERFLOW_EN defined, overflow SHALL set on a dropped write (REQ-017) and clear on ovf_clr=1.
REQ-037 With the macro defined, set SHALL win over ovf_clr in the same cycle.
REQ-038 Without UART_TX_BUFFER_OVERFLOW_EN, overflow SHALL be constant 0 and ovf_clr SHALL be ignored; ports SHALL remain present.

Verification
REQ-039 Reset: rst=1 for 2 cycles -> empty=1, full=0, count=0, tx_send=0, tx_data=8'h00.
REQ-040 Ordering: write 8'h41, 8'h42, 8'h43 with tx_ready=1; model ready low 3 cycles after send -> tx_data sequence 41, 42, 43, one send pulse each, count returns to 0.
REQ-041 Fill to capacity: DEPTH=16, tx_ready=0, write 17 bytes -> full=1, count=16, 17th byte dropped.
REQ-042 Overflow flag: after the 17-byte fill with the macro defined -> overflow=1 until ovf_clr; with the macro undefined -> overflow=0 throughout.
REQ-043 Simultaneous write and pop at count=5 -> count stays 5, order preserved.
REQ-044 flush during BUSY with count=4 -> count=0 next cycle, current tx_data held until tx_ready=1, no further send.

Source files
------------

// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer
// ----------------------------------------------------------------------------
// Byte FIFO that feeds a UART transmitter. The host pushes bytes with wr_en.
// A three-state handshake FSM (IDLE, REQ, BUSY) pops the head byte into a
// holding register and requests a transmission.
//
// Parameters
//   DEPTH     FIFO entries. Must be a power of two in the range 2..256.
//
// Ports
//   clk       system clock. All logic updates on the rising edge.
//   rst       synchronous active-high reset. Overrides every other input.
//   wr_data   host byte to enqueue.
//   wr_en     enqueue request. One byte is taken per cycle. A request made
//             while the FIFO is full is dropped.
//   flush     discards the FIFO contents. It does not disturb a byte that is
//             already in flight.
//   full      the FIFO holds DEPTH entries.
//   empty     the FIFO holds no entries.
//   count     current FIFO occupancy, 0..DEPTH.
//   tx_data   byte presented to the transmitter. It changes only on a pop.
//   tx_send   registered transmit request. It is high only in REQ.
//   tx_ready  transmitter idle indication.
//   overflow  sticky flag that records a write made while the FIFO was full.
//   ovf_clr   clears overflow.
//
// Build option
//   UART_TX_BUFFER_OVERFLOW_EN  When this macro is defined, the overflow flag
//                               is implemented. When it is left undefined,
//                               overflow is tied to 0 and ovf_clr is ignored.
//                               Both ports remain present in either build.
// ----------------------------------------------------------------------------
module uart_tx_buffer #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               wr_data,
  input  logic                     wr_en,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               tx_data,
  output logic                     tx_send,
  input  logic                     tx_ready,
  output logic                     overflow,
  input  logic                     ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    BUSY = 2'd2
  } state_t;

  state_t         state;
  logic [7:0]     mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count_q;
  logic           wr_fire;
  logic           pop;

  // Occupancy flags are decoded from the registered count, so they always
  // describe the state before the current edge.
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  // A write is accepted only when the FIFO is not full before the edge.
  // A flush in the same cycle discards the write.
  // A pop is taken only from IDLE with data waiting and the transmitter idle.
  // Because empty reflects the pre-edge count, a byte written into an empty
  // FIFO can leave no earlier than the following cycle.
  assign wr_fire = wr_en && !full && !flush;
  assign pop     = (state == IDLE) && !empty && tx_ready;

  // Storage array. It needs no reset, because the pointers and count define
  // which entries are valid.
  always_ff @(posedge clk) begin
    if (!rst && wr_fire) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Read/write pointers and occupancy.
  // DEPTH is a power of two, so the natural roll-over of an AW-bit pointer
  // wraps it from DEPTH-1 to 0.
  // A write and a pop in the same cycle both advance their pointers and leave
  // count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_fire, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Transmit handshake FSM.
  // IDLE pops the head byte into tx_data and raises tx_send.
  // REQ holds the request until the transmitter drops tx_ready.
  // BUSY waits for tx_ready to return, then goes back to IDLE.
  // Because IDLE always lasts at least one cycle, the transmitter's internal
  // enable has time to clear before the next request arrives.
  // flush is deliberately absent here, so a byte in flight always completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tx_send <= 1'b0;
      tx_data <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            tx_data <= mem[rd_ptr];
            tx_send <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          if (!tx_ready) begin
            tx_send <= 1'b0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (tx_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          tx_send <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

`ifdef UART_TX_BUFFER_OVERFLOW_EN
  logic ovf_q;

  // Sticky overflow flag. A dropped write sets it, and ovf_clr clears it.
  // If both happen in the same cycle, the set wins so that no event is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (wr_en && full && !flush) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign overflow = ovf_q;
`else
  logic unused_ovf_clr;

  // The overflow logic is not built. The flag reads as zero and the clear
  // input has no effect.
  assign overflow       = 1'b0;
  assign unused_ovf_clr = ovf_clr;
`endif

endmodule

// File: tb/tb_uart_tx_buffer.sv
// tb_uart_tx_buffer
// ----------------------------------------------------------------------------
// Self-checking bench for uart_tx_buffer with DEPTH = 16.
//
// The bench keeps a behavioural reference model: a byte queue for the FIFO,
// together with handshake flags that track the transmit request. Directed
// sequences cover the following cases:
//   - reset
//   - byte ordering through a transmitter emulation
//   - filling to capacity and dropping a write when full
//   - overflow set and clear
//   - a write and a pop in the same cycle
//   - flush while a byte is in flight
// A randomized run follows the directed sequences.
// ----------------------------------------------------------------------------
module tb_uart_tx_buffer;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef UART_TX_BUFFER_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    wr_data;
  logic          wr_en;
  logic          flush;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic [7:0]    tx_data;
  logic          tx_send;
  logic          tx_ready;
  logic          overflow;
  logic          ovf_clr;

  int assert_count = 0;
  int fail_count   = 0;

  // Reference model state.
  logic [7:0] mq[$];
  bit         m_send;
  bit         m_wait;
  bit         m_ovf;
  logic [7:0] m_data;

  // Transmitter emulation and capture of the bytes sent.
  int         low_left;
  logic [7:0] sent_q[$];
  int         send_pulses;
  bit         prev_send;

  always #5 clk = ~clk;

  uart_tx_buffer #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .flush    (flush),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .tx_data  (tx_data),
    .tx_send  (tx_send),
    .tx_ready (tx_ready),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  // Every comparison passes through this task, which counts it and reports
  // any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_count++;
    if (obs !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the reference model across one clock edge.
  // The model first takes any pop from the pre-edge queue. It then applies
  // flush, and finally appends the write if it was accepted.
  task automatic modelStep(input logic r, input logic we, input logic [7:0] wd,
                           input logic fl, input logic tr, input logic oc);
    bit pre_full;
    bit pre_empty;
    bit accept;
    bit dropped;
    if (r) begin
      mq.delete();
      m_send = 1'b0;
      m_wait = 1'b0;
      m_data = 8'h00;
      m_ovf  = 1'b0;
      return;
    end
    pre_full  = (mq.size() == DEPTH);
    pre_empty = (mq.size() == 0);
    accept    = we && !pre_full && !fl;
    dropped   = we && pre_full && !fl;
    if (m_send) begin
      if (!tr) begin
        m_send = 1'b0;
        m_wait = 1'b1;
      end
    end else if (m_wait) begin
      if (tr) m_wait = 1'b0;
    end else if (!pre_empty && tr) begin
      m_data = mq.pop_front();
      m_send = 1'b1;
    end
    if (fl) mq.delete();
    if (accept) mq.push_back(wd);
    if (OVF_EN) begin
      if (dropped) m_ovf = 1'b1;
      else if (oc) m_ovf = 1'b0;
    end else begin
      m_ovf = 1'b0;
    end
  endtask

  // Drive one cycle of inputs, step the model at the edge, then compare all
  // outputs shortly after the edge. Rising edges of tx_send are recorded.
  task automatic applyStimulus(input logic r, input logic we, input logic [7:0] wd,
                               input logic fl, input logic tr, input logic oc);
    rst      = r;
    wr_en    = we;
    wr_data  = wd;
    flush    = fl;
    tx_ready = tr;
    ovf_clr  = oc;
    @(posedge clk);
    modelStep(r, we, wd, fl, tr, oc);
    #1;
    checkOutput("count",    32'(count),    32'(mq.size()));
    checkOutput("empty",    32'(empty),    32'(mq.size() == 0));
    checkOutput("full",     32'(full),     32'(mq.size() == DEPTH));
    checkOutput("tx_send",  32'(tx_send),  32'(m_send));
    checkOutput("tx_data",  32'(tx_data),  32'(m_data));
    checkOutput("overflow", 32'(overflow), 32'(m_ovf));
    if (r) begin
      prev_send = 1'b0;
    end else begin
      if (tx_send && !prev_send) begin
        sent_q.push_back(tx_data);
        send_pulses++;
      end
      prev_send = tx_send;
    end
  endtask

  // Emulated transmitter. When a send request appears, tx_ready is held low
  // for the next three cycles.
  task automatic xmitCycle(input logic we, input logic [7:0] wd);
    logic tr;
    tr = (low_left == 0);
    if (low_left > 0) low_left--;
    applyStimulus(1'b0, we, wd, 1'b0, tr, 1'b0);
    if (m_send && low_left == 0) low_left = 3;
  endtask

  task automatic doReset(input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    sent_q.delete();
    send_pulses = 0;
    low_left    = 0;
  endtask

  initial begin
    int base_pulses;

    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0; tx_ready = 1'b0; ovf_clr = 1'b0;
    m_send = 1'b0; m_wait = 1'b0; m_ovf = 1'b0; m_data = 8'h00;
    low_left = 0; send_pulses = 0; prev_send = 1'b0;

    // Reset state: hold reset for two cycles, then check the idle outputs.
    doReset(2);
    checkOutput("rst_empty",   32'(empty),   32'd1);
    checkOutput("rst_full",    32'(full),    32'd0);
    checkOutput("rst_count",   32'(count),   32'd0);
    checkOutput("rst_tx_send", 32'(tx_send), 32'd0);
    checkOutput("rst_tx_data", 32'(tx_data), 32'h00);

    // Ordering: bytes must leave in the order they were written, with one
    // send pulse per byte.
    xmitCycle(1'b1, 8'h41);
    xmitCycle(1'b1, 8'h42);
    xmitCycle(1'b1, 8'h43);
    for (int i = 0; i < 30; i++) xmitCycle(1'b0, 8'h00);
    checkOutput("ord_pulses", 32'(send_pulses), 32'd3);
    checkOutput("ord_size",   32'(sent_q.size()), 32'd3);
    if (sent_q.size() == 3) begin
      checkOutput("ord_b0", 32'(sent_q[0]), 32'h41);
      checkOutput("ord_b1", 32'(sent_q[1]), 32'h42);
      checkOutput("ord_b2", 32'(sent_q[2]), 32'h43);
    end
    checkOutput("ord_count", 32'(count), 32'd0);

    // Fill to capacity with the transmitter busy. The 17th byte is dropped.
    doReset(1);
    for (int i = 0; i < 17; i++) applyStimulus(1'b0, 1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
    checkOutput("fill_full",  32'(full),     32'd1);
    checkOutput("fill_count", 32'(count),    32'd16);
    checkOutput("fill_ovf",   32'(overflow), 32'(OVF_EN));
    // A dropped write and a clear in the same cycle: the set wins.
    applyStimulus(1'b0, 1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
    checkOutput("ovf_set_wins", 32'(overflow), 32'(OVF_EN));
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("ovf_cleared", 32'(overflow), 32'd0);
    for (int i = 0; i < 120; i++) xmitCycle(1'b0, 8'h00);
    checkOutput("fill_drain_size", 32'(sent_q.size()), 32'd16);
    if (sent_q.size() == 16) begin
      for (int i = 0; i < 16; i++) checkOutput("fill_drain_byte", 32'(sent_q[i]), 32'(8'h10 + i));
    end

    // Simultaneous write and pop at count 5: count is unchanged and the
    // order is preserved.
    doReset(1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0);
    checkOutput("simul_count", 32'(count),   32'd5);
    checkOutput("simul_data",  32'(tx_data), 32'h60);
    for (int i = 0; i < 50; i++) xmitCycle(1'b0, 8'h00);
    checkOutput("simul_size", 32'(sent_q.size()), 32'd6);
    if (sent_q.size() == 6) begin
      for (int i = 0; i < 5; i++) checkOutput("simul_byte", 32'(sent_q[i]), 32'(8'h60 + i));
      checkOutput("simul_last", 32'(sent_q[5]), 32'hA5);
    end

    // Flush while a byte is in flight (BUSY) with count 4. The in-flight
    // byte is held, and no further send follows.
    doReset(1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 8'(8'h70 + i), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("flush_pre_count", 32'(count), 32'd4);
    base_pulses = send_pulses;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("flush_count",   32'(count),   32'd0);
    checkOutput("flush_data",    32'(tx_data), 32'h70);
    checkOutput("flush_tx_send", 32'(tx_send), 32'd0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("flush_no_send", 32'(send_pulses - base_pulses), 32'd0);
    checkOutput("flush_held",    32'(tx_data), 32'h70);

    // Randomized traffic, checked cycle by cycle against the model.
    doReset(1);
    for (int i = 0; i < 3000; i++) begin
      logic r, we, fl, tr, oc;
      r  = ($urandom_range(0, 199) == 0);
      we = ($urandom_range(0, 99) < ((i < 1500) ? 50 : 15));
      fl = !we && ($urandom_range(0, 39) == 0);
      tr = ($urandom_range(0, 9) < 6);
      oc = ($urandom_range(0, 9) == 0);
      applyStimulus(r, we, 8'($urandom), fl, tr, oc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
